// File: rtl/regfile_pkg.sv
// regfile_pkg: shared parameters for the register file, its write arbiter
// and decode.
//   DW   - data width
//   AW   - register address width
//   NREG - number of architectural registers (2**AW)
//   CW   - width of each per-register outstanding-write counter
//   SRC_ALU / SRC_MEM - writeback source indices used by the round-robin state
package regfile_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;
  localparam int CW   = 2;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register count of writes that have been issued but not
// yet committed to the register file.
//   clk, rst   - clock; synchronous active-high reset clears every count
//   iss_valid  - decode issuing an instruction with destination iss_addr
//   iss_addr   - destination register of the issuing instruction
//   iss_ready  - low when the destination count is saturated (never for r0)
//   dec_valid  - register file commits a write this edge (registered RW)
//   dec_addr   - register being committed (registered DA)
//   pending    - bit i set while register i has an outstanding write
module reg_scoreboard #(
  parameter int AW = regfile_pkg::AW,
  parameter int CW = regfile_pkg::CW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_ready,
  input  logic                 dec_valid,
  input  logic [AW-1:0]        dec_addr,
  output logic [(2**AW)-1:0]   pending
);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [(2**AW)-1:0] sat_s;
  logic               inc_s;

  // r0 is never tracked, so it can always accept an issue
  assign iss_ready = !sat_s[iss_addr] || (iss_addr == {AW{1'b0}});
  assign inc_s     = iss_valid && iss_ready && (iss_addr != {AW{1'b0}});

  for (genvar i = 0; i < (2**AW); i++) begin : g_cnt
    logic [CW-1:0] cnt_r;
    logic          inc_hit_s;
    logic          dec_hit_s;

    assign inc_hit_s = inc_s && (iss_addr == AW'(i));
    assign dec_hit_s = dec_valid && (dec_addr == AW'(i));

    // Outstanding-write counter: coincident inc/dec cancel, a decrement of
    // zero is a protocol error and leaves the count at zero
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_r <= CNT_ZERO;
      end else if (inc_hit_s && !dec_hit_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else if (dec_hit_s && !inc_hit_s && (cnt_r != CNT_ZERO)) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end

    assign sat_s[i]   = (cnt_r == CNT_MAX);
    assign pending[i] = (cnt_r != CNT_ZERO);
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file's single write port between
// the ALU and load writeback sources and tracks in-flight writes.
//   clk, rst                      - clock; synchronous active-high reset
//   alu_valid/alu_addr/alu_data   - ALU writeback request, alu_ready = grant
//   mem_valid/mem_addr/mem_data   - load writeback request, mem_ready = grant
//   iss_valid/iss_addr/iss_ready  - decode destination issue handshake
//   RW/DA/D_DATA                  - registered register-file write port
//   pending                       - per-register outstanding-write flags
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DW = regfile_pkg::DW,
  parameter int AW = regfile_pkg::AW,
  parameter int CW = regfile_pkg::CW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [AW-1:0]       alu_addr,
  input  logic [DW-1:0]       alu_data,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [AW-1:0]       mem_addr,
  input  logic [DW-1:0]       mem_data,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [AW-1:0]       iss_addr,
  output logic                RW,
  output logic [AW-1:0]       DA,
  output logic [DW-1:0]       D_DATA,
  output logic [(2**AW)-1:0]  pending
);

  logic          last_r;
  logic          tie_s;
  logic          grant_alu_s;
  logic          grant_mem_s;
  logic [AW-1:0] win_addr_s;
  logic [DW-1:0] win_data_s;

  // Grant selection: a lone request wins outright; on a tie the source that
  // did not win the previous tie is chosen
  always_comb begin
    tie_s       = alu_valid && mem_valid;
    grant_alu_s = 1'b0;
    grant_mem_s = 1'b0;
    win_addr_s  = alu_addr;
    win_data_s  = alu_data;
    if (tie_s) begin
      grant_alu_s = (last_r == SRC_MEM);
      grant_mem_s = (last_r != SRC_MEM);
    end else begin
      grant_alu_s = alu_valid;
      grant_mem_s = mem_valid;
    end
    if (grant_mem_s) begin
      win_addr_s = mem_addr;
      win_data_s = mem_data;
    end else begin
      win_addr_s = alu_addr;
      win_data_s = alu_data;
    end
  end

  assign alu_ready = grant_alu_s;
  assign mem_ready = grant_mem_s;

  // Write-port registers and round-robin state; r0 writes handshake but
  // never raise RW, and DA/D_DATA hold when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      RW     <= 1'b0;
      DA     <= {AW{1'b0}};
      D_DATA <= {DW{1'b0}};
      last_r <= SRC_MEM;
    end else begin
      if (grant_alu_s || grant_mem_s) begin
        RW     <= (win_addr_s != {AW{1'b0}});
        DA     <= win_addr_s;
        D_DATA <= win_data_s;
      end else begin
        RW     <= 1'b0;
      end
      if (tie_s) begin
        last_r <= grant_alu_s ? SRC_ALU : SRC_MEM;
      end
    end
  end

  // Counts retire on the edge the register file commits, i.e. while RW is high
  reg_scoreboard #(
    .AW (AW),
    .CW (CW)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .dec_valid (RW),
    .dec_addr  (DA),
    .pending   (pending)
  );

endmodule
